// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide co-unit for EX: one bit per cycle, results land in HI/LO.
// Define MULDIV_DIV_EN to build the restoring divider and divide-by-zero handling.
module ex_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic             Op,
  input  logic             Signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             DivByZero
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e             state_q, state_d;
  logic               op_q;
  logic               neg_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CntW-1:0]    cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q, dbz_out_q;

  logic               a_neg, b_neg, start_ok, fast_fix, last_iter;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, calc_next, prod;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

`ifdef MULDIV_DIV_EN
  logic               rem_neg_q, dbz_q;
  logic               div_zero, rem_ge;
  logic [WIDTH:0]     rem_shift, rem_sub;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   quo, rem;
`endif

  always_comb begin
    a_neg     = Signed & A[WIDTH-1];
    b_neg     = Signed & B[WIDTH-1];
    a_mag     = a_neg ? -A : A;
    b_mag     = b_neg ? -B : B;
    start_ok  = (state_q == StIdle) && Start;
    last_iter = (cnt_q == CntW'(WIDTH - 1));
`ifdef MULDIV_DIV_EN
    div_zero  = Op && (B == '0);
    fast_fix  = div_zero;
`else
    fast_fix  = Op;
`endif
  end

  // Shift-add: acc = {partial, multiplier}; multiplier bits drop out of the bottom.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    calc_next = mul_next;
    prod      = neg_q ? -acc_q : acc_q;
    fix_hi    = prod[2*WIDTH-1:WIDTH];
    fix_lo    = prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
    // Restoring divide: acc = {remainder, dividend/quotient}; quotient bits enter at LSB.
    rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_ge    = rem_shift >= {1'b0, opnd_q};
    rem_sub   = rem_shift - {1'b0, opnd_q};
    div_next  = {(rem_ge ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], rem_ge};
    quo       = acc_q[WIDTH-1:0];
    rem       = acc_q[2*WIDTH-1:WIDTH];
    if (op_q) begin
      calc_next = div_next;
      if (dbz_q) begin
        fix_hi = acc_q[2*WIDTH-1:WIDTH];
        fix_lo = acc_q[WIDTH-1:0];
      end else begin
        fix_hi = rem_neg_q ? -rem : rem;
        fix_lo = neg_q ? -quo : quo;
      end
    end
`else
    if (op_q) begin
      fix_hi = '0;
      fix_lo = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (Start) state_d = fast_fix ? StFix : StCalc;
      StCalc:  if (last_iter) state_d = StFix;
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    Busy      = (state_q != StIdle);
    Done      = done_q;
    HI        = hi_q;
    LO        = lo_q;
    DivByZero = dbz_out_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= 1'b0;
      neg_q     <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      rem_neg_q <= 1'b0;
      dbz_q     <= 1'b0;
`endif
    end else begin
      done_q <= (state_q == StFix);
      if (start_ok) begin
        op_q      <= Op;
        neg_q     <= a_neg ^ b_neg;
        cnt_q     <= '0;
        dbz_out_q <= 1'b0;
        acc_q     <= {{WIDTH{1'b0}}, b_mag};
        opnd_q    <= a_mag;
`ifdef MULDIV_DIV_EN
        rem_neg_q <= a_neg;
        dbz_q     <= div_zero;
        if (Op) begin
          // Divide by zero parks the raw dividend and all-ones quotient for FIX.
          acc_q  <= div_zero ? {A, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, a_mag};
          opnd_q <= b_mag;
        end
`endif
      end else if (state_q == StCalc) begin
        acc_q <= calc_next;
        cnt_q <= cnt_q + 1'b1;
      end else if (state_q == StFix) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
`ifdef MULDIV_DIV_EN
        dbz_out_q <= op_q & dbz_q;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: arithmetic model plus per-cycle handshake/result checks.
module tb_ex_muldiv_unit;
  logic        clk = 1'b0, rst_n = 1'b1, Start = 1'b0, Op = 1'b0, Signed = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic        Busy, Done, DivByZero;
  logic [31:0] HI, LO;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Op(Op), .Signed(Signed), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .HI(HI), .LO(LO), .DivByZero(DivByZero)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  bit          act_valid = 1'b0;
  int          act_k = 0, act_done = 0;
  logic [31:0] pend_hi = '0, pend_lo = '0, exp_hi = '0, exp_lo = '0;
  logic        pend_dbz = 1'b0, exp_dbz = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Returns {dbz, hi, lo} from plain arithmetic.
  function automatic logic [64:0] model(input logic op, input logic sg,
                                        input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    sa = sg ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sg ? longint'($signed(b)) : longint'({32'b0, b});
    if (!op) begin
      p = 64'(sa * sb);
      return {1'b0, p};
    end
`ifdef MULDIV_DIV_EN
    begin
      longint q, r;
      if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
      q = sa / sb;
      r = sa % sb;
      return {1'b0, r[31:0], q[31:0]};
    end
`else
    return 65'b0;
`endif
  endfunction

  function automatic bit is_fast(input logic op, input logic [31:0] b);
`ifdef MULDIV_DIV_EN
    return op && (b == 32'd0);
`else
    return op;
`endif
  endfunction

  // Per-cycle handshake and held-result check.
  always @(negedge clk) begin
    bit eb, ed;
    if (rst_n) begin
      eb = act_valid && edge_cnt >= act_k && edge_cnt < act_done;
      ed = act_valid && edge_cnt == act_done;
      if (ed) begin
        exp_hi  = pend_hi;
        exp_lo  = pend_lo;
        exp_dbz = pend_dbz;
      end
      chk("cyc_busy", Busy, eb);
      chk("cyc_done", Done, ed);
      chk("cyc_hi", HI, exp_hi);
      chk("cyc_lo", LO, exp_lo);
      chk("cyc_dbz", DivByZero, exp_dbz);
    end
  end

  task automatic start_op(input logic op, input logic sg, input logic [31:0] a,
                          input logic [31:0] b);
    logic [64:0] m;
    m = model(op, sg, a, b);
    Op = op; Signed = sg; A = a; B = b; Start = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    A = $urandom;
    B = $urandom;
    act_k    = edge_cnt;
    act_done = edge_cnt + (is_fast(op, b) ? 1 : 33);
    {pend_dbz, pend_hi, pend_lo} = m;
    exp_dbz   = 1'b0;
    act_valid = 1'b1;
  endtask

  task automatic wait_check(input string name, input logic [31:0] ehi, input logic [31:0] elo,
                            input logic edbz, input int lat);
    int n = 0;
    while (!Done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!Done) begin
      chk({name, "_timeout"}, 64'd0, 64'd1);
    end else begin
      chk({name, "_lat"}, 64'(edge_cnt - act_k), 64'(lat));
      chk({name, "_hi"}, HI, ehi);
      chk({name, "_lo"}, LO, elo);
      chk({name, "_dbz"}, DivByZero, edbz);
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_hi", HI, 0);
    chk("rst_lo", LO, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Each wait_check returns in the Done cycle, so every following start is back-to-back.
    start_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_check("umul_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33);
    start_op(1'b0, 1'b1, -32'sd3, 32'd7);
    wait_check("smul_m3x7", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33);
    start_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_check("smul_m1xm1", 32'h0, 32'h1, 1'b0, 33);

`ifdef MULDIV_DIV_EN
    start_op(1'b1, 1'b1, -32'sd7, 32'd2);
    wait_check("sdiv_m7d2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
    start_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);
    wait_check("udiv", 32'h1, 32'h7FFF_FFFC, 1'b0, 33);
    start_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_check("sdiv_ovf", 32'h0, 32'h8000_0000, 1'b0, 33);
    start_op(1'b1, 1'b0, 32'd5, 32'd0);
    wait_check("div0", 32'd5, 32'hFFFF_FFFF, 1'b1, 1);
`else
    start_op(1'b1, 1'b1, -32'sd7, 32'd2);
    wait_check("nodiv_sdiv", 32'h0, 32'h0, 1'b0, 1);
    start_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);
    wait_check("nodiv_udiv", 32'h0, 32'h0, 1'b0, 1);
    start_op(1'b1, 1'b0, 32'd5, 32'd0);
    wait_check("nodiv_div0", 32'h0, 32'h0, 1'b0, 1);
`endif

    start_op(1'b0, 1'b0, 32'h1234, 32'h10);
    chk("dbz_clear", DivByZero, 0);
    wait_check("umul_small", 32'h0, 32'h0001_2340, 1'b0, 33);

    // A second Start mid-CALC must not disturb the running multiply.
    start_op(1'b0, 1'b0, 32'd100, 32'd200);
    repeat (5) @(negedge clk);
    Op = 1'b1; Signed = 1'b1; A = 32'd7; B = 32'd9; Start = 1'b1;
    @(posedge clk);
    #1 Start = 1'b0;
    wait_check("ignored_start", 32'h0, 32'h0000_4E20, 1'b0, 33);

    // Asynchronous reset at iteration 10 discards the in-flight operation.
    start_op(1'b0, 1'b1, 32'd12345, -32'sd6789);
    repeat (10) @(posedge clk);
    #2;
    rst_n     = 1'b0;
    act_valid = 1'b0;
    exp_hi = '0; exp_lo = '0; exp_dbz = 1'b0;
    #1;
    chk("arst_busy", Busy, 0);
    chk("arst_done", Done, 0);
    chk("arst_hi", HI, 0);
    chk("arst_lo", LO, 0);
    chk("arst_dbz", DivByZero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_op(1'b0, 1'b1, -32'sd12345, 32'd6789);
    wait_check("post_rst_smul", 32'hFFFF_FFFF, 32'hFB01_2863, 1'b0, 33);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
